// File: rtl/fpga250_swb_pkg.sv
// fpga250 switch box shared definitions: select codes, track width, chain length.
// Optional macro SWB_CFG_PARITY_EN appends one even-parity bit to the config chain.
package fpga250_swb_pkg;

    localparam logic [1:0] SEL_OFF = 2'd0;
    localparam logic [1:0] SEL_CW  = 2'd1;
    localparam logic [1:0] SEL_OPP = 2'd2;
    localparam logic [1:0] SEL_CCW = 2'd3;

    localparam int BITS_PER_TRACK = 8;

`ifdef SWB_CFG_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int cfg_bits(input int w);
        return BITS_PER_TRACK * w + PARITY_BITS;
    endfunction

    // Pick one of the three neighbouring sides by select code.
    function automatic logic side_pick(
        input logic [1:0] code,
        input logic       cw,
        input logic       opp,
        input logic       ccw
    );
        logic r;
        r = 1'b0;
        unique case (code)
            SEL_OFF: r = 1'b0;
            SEL_CW:  r = cw;
            SEL_OPP: r = opp;
            SEL_CCW: r = ccw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/swb_track_mux.sv
// One track of the switch box: four 4:1 side muxes steered by an 8-bit slice.
// Ports: sel (N[1:0],E[3:2],S[5:4],W[7:6]), north/east/south/west in, to_* out.
module swb_track_mux
    import fpga250_swb_pkg::*;
(
    input  logic [BITS_PER_TRACK-1:0] sel,
    input  logic                      north,
    input  logic                      east,
    input  logic                      south,
    input  logic                      west,
    output logic                      to_north,
    output logic                      to_east,
    output logic                      to_south,
    output logic                      to_west
);

    // Clockwise order N->E->S->W; code 1 takes the next clockwise side.
    assign to_north = side_pick(sel[1:0], east,  south, west);
    assign to_east  = side_pick(sel[3:2], south, west,  north);
    assign to_south = side_pick(sel[5:4], west,  north, east);
    assign to_west  = side_pick(sel[7:6], north, east,  south);

endmodule

// File: rtl/universal_switch_box_cfg.sv
// fpga250 switch box with its own serial config chain, shadow/active registers.
// Ports: clk, rst_n, {north,east,south,west}_{in,out}[W], cfg_en/in/out, cfg_load,
//        load_ack, cfg_full, cfg_valid, cfg_err. Macro SWB_CFG_PARITY_EN adds parity.
module universal_switch_box_cfg
    import fpga250_swb_pkg::*;
#(
    parameter int W       = 8,
    parameter int OUT_REG = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] north_in,
    input  logic [W-1:0] east_in,
    input  logic [W-1:0] south_in,
    input  logic [W-1:0] west_in,
    output logic [W-1:0] north_out,
    output logic [W-1:0] east_out,
    output logic [W-1:0] south_out,
    output logic [W-1:0] west_out,
    input  logic         cfg_en,
    input  logic         cfg_in,
    output logic         cfg_out,
    input  logic         cfg_load,
    output logic         load_ack,
    output logic         cfg_full,
    output logic         cfg_valid,
    output logic         cfg_err
);

    localparam int CW   = cfg_bits(W);
    localparam int RW   = BITS_PER_TRACK * W;
    localparam int CNTW = $clog2(CW + 1);
    localparam logic [CNTW-1:0] CW_CNT = CNTW'(CW);

    logic [CW-1:0]   shadow;
    logic [RW-1:0]   active;
    logic [RW-1:0]   routing;
    logic [CNTW-1:0] count;
    logic            full;
    logic            check_ok;
    logic            accept;

    assign full = (count == CW_CNT);

`ifdef SWB_CFG_PARITY_EN
    // shadow[0] is the parity bit; the whole chain must XOR to 0.
    assign check_ok = ~(^shadow);
    assign routing  = shadow[CW-1:1];
`else
    assign check_ok = 1'b1;
    assign routing  = shadow;
`endif

    assign accept = cfg_load & full & check_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            active    <= '0;
            count     <= '0;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
            load_ack  <= 1'b0;
        end else begin
            if (cfg_en)
                shadow <= {shadow[CW-2:0], cfg_in};
            if (accept) begin
                active    <= routing;
                cfg_valid <= 1'b1;
            end
            if (cfg_load)
                cfg_err <= ~accept;
            load_ack <= accept;
            // A commit takes the pre-shift shadow; a concurrent shift
            // becomes the first bit of the next load.
            if (accept)
                count <= cfg_en ? CNTW'(1) : '0;
            else if (cfg_en && !full)
                count <= count + 1'b1;
        end
    end

    assign cfg_out  = shadow[CW-1];
    assign cfg_full = full;

    logic [W-1:0] n_nx, e_nx, s_nx, w_nx;

    for (genvar i = 0; i < W; i++) begin : g_trk
        swb_track_mux u_mux (
            .sel      (active[BITS_PER_TRACK*i +: BITS_PER_TRACK]),
            .north    (north_in[i]),
            .east     (east_in[i]),
            .south    (south_in[i]),
            .west     (west_in[i]),
            .to_north (n_nx[i]),
            .to_east  (e_nx[i]),
            .to_south (s_nx[i]),
            .to_west  (w_nx[i])
        );
    end

    if (OUT_REG != 0) begin : g_oreg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                north_out <= '0;
                east_out  <= '0;
                south_out <= '0;
                west_out  <= '0;
            end else begin
                north_out <= n_nx;
                east_out  <= e_nx;
                south_out <= s_nx;
                west_out  <= w_nx;
            end
        end
    end else begin : g_comb
        assign north_out = n_nx;
        assign east_out  = e_nx;
        assign south_out = s_nx;
        assign west_out  = w_nx;
    end

endmodule

// File: tb/tb_universal_switch_box_cfg.sv
// Bench for universal_switch_box_cfg: W=4, combinational and registered outputs.
// Behavioural model checked every cycle plus directed literal expectations.
module tb_universal_switch_box_cfg;

    localparam int W = 4;
`ifdef SWB_CFG_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int CW = 8 * W + P;
    localparam logic [8*W-1:0] CFG_A = {W{8'h39}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] n_in = '0, e_in = '0, s_in = '0, w_in = '0;
    logic cfg_en = 1'b0, cfg_in = 1'b0, cfg_load = 1'b0;

    logic [W-1:0] north_out, east_out, south_out, west_out;
    logic cfg_out, load_ack, cfg_full, cfg_valid, cfg_err;
    logic [W-1:0] r_north, r_east, r_south, r_west;
    logic r_cfg_out, r_ack, r_full, r_valid, r_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    universal_switch_box_cfg #(.W(W), .OUT_REG(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .north_in(n_in), .east_in(e_in), .south_in(s_in), .west_in(w_in),
        .north_out(north_out), .east_out(east_out),
        .south_out(south_out), .west_out(west_out),
        .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfg_out),
        .cfg_load(cfg_load), .load_ack(load_ack), .cfg_full(cfg_full),
        .cfg_valid(cfg_valid), .cfg_err(cfg_err)
    );

    universal_switch_box_cfg #(.W(W), .OUT_REG(1)) dut_r (
        .clk(clk), .rst_n(rst_n),
        .north_in(n_in), .east_in(e_in), .south_in(s_in), .west_in(w_in),
        .north_out(r_north), .east_out(r_east),
        .south_out(r_south), .west_out(r_west),
        .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(r_cfg_out),
        .cfg_load(cfg_load), .load_ack(r_ack), .cfg_full(r_full),
        .cfg_valid(r_valid), .cfg_err(r_err)
    );

    // Model: m_q[0] is the oldest bit in the chain (the one on cfg_out).
    bit         m_q [CW];
    logic [1:0] m_sel [W][4];
    logic [W-1:0] m_reg [4];
    int m_cnt;
    bit m_valid, m_err, m_ack;

    // side 0..3 = N,E,S,W; code c selects side (s+c)%4, code 0 = off.
    function automatic logic [W-1:0] route(input int s,
        input logic [W-1:0] n, input logic [W-1:0] e,
        input logic [W-1:0] so, input logic [W-1:0] w);
        logic [W-1:0] ins [4];
        logic [W-1:0] r;
        ins[0] = n; ins[1] = e; ins[2] = so; ins[3] = w;
        r = '0;
        for (int t = 0; t < W; t++)
            if (m_sel[t][s] != 2'd0)
                r[t] = ins[(s + int'(m_sel[t][s])) % 4][t];
        return r;
    endfunction

    function automatic bit m_parity();
        bit p;
        p = 1'b0;
        for (int j = 0; j < CW; j++) p ^= m_q[j];
        return p;
    endfunction

    function automatic bit m_accept();
        return cfg_load && (m_cnt == CW) && (P == 0 || !m_parity());
    endfunction

    // shadow[j] == m_q[CW-1-j]; routing bit k lives at shadow[k+P].
    function automatic bit abit(input int k);
        return m_q[CW - 1 - k - P];
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        if (!rst_n) begin
            for (int j = 0; j < CW; j++) m_q[j] <= 1'b0;
            for (int t = 0; t < W; t++)
                for (int s = 0; s < 4; s++) m_sel[t][s] <= 2'd0;
            for (int s = 0; s < 4; s++) m_reg[s] <= '0;
            m_cnt <= 0;
            m_valid <= 1'b0;
            m_err <= 1'b0;
            m_ack <= 1'b0;
        end else begin
            for (int s = 0; s < 4; s++)
                m_reg[s] <= route(s, n_in, e_in, s_in, w_in);
            if (cfg_en) begin
                for (int j = 0; j < CW - 1; j++) m_q[j] <= m_q[j+1];
                m_q[CW-1] <= cfg_in;
            end
            if (m_accept()) begin
                for (int t = 0; t < W; t++)
                    for (int s = 0; s < 4; s++)
                        m_sel[t][s] <= {abit(8*t + 2*s + 1), abit(8*t + 2*s)};
                m_valid <= 1'b1;
                m_cnt <= cfg_en ? 1 : 0;
            end else if (cfg_en && m_cnt < CW) begin
                m_cnt <= m_cnt + 1;
            end
            if (cfg_load) m_err <= !m_accept();
            m_ack <= m_accept();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        chk("north_out", 32'(north_out), 32'(route(0, n_in, e_in, s_in, w_in)));
        chk("east_out",  32'(east_out),  32'(route(1, n_in, e_in, s_in, w_in)));
        chk("south_out", 32'(south_out), 32'(route(2, n_in, e_in, s_in, w_in)));
        chk("west_out",  32'(west_out),  32'(route(3, n_in, e_in, s_in, w_in)));
        chk("r_north",   32'(r_north), 32'(m_reg[0]));
        chk("r_east",    32'(r_east),  32'(m_reg[1]));
        chk("r_south",   32'(r_south), 32'(m_reg[2]));
        chk("r_west",    32'(r_west),  32'(m_reg[3]));
        chk("cfg_out",   32'(cfg_out),   32'(m_q[0]));
        chk("cfg_full",  32'(cfg_full),  32'(m_cnt == CW));
        chk("cfg_valid", 32'(cfg_valid), 32'(m_valid));
        chk("cfg_err",   32'(cfg_err),   32'(m_err));
        chk("load_ack",  32'(load_ack),  32'(m_ack));
        chk("r_cfg_out", 32'(r_cfg_out), 32'(m_q[0]));
        chk("r_valid",   32'(r_valid),   32'(m_valid));
        chk("r_ack",     32'(r_ack),     32'(m_ack));
        chk("r_full",    32'(r_full),    32'(m_cnt == CW));
        chk("r_err",     32'(r_err),     32'(m_err));
    end

    task automatic cyc(input bit en, input bit din, input bit ld);
        cfg_en = en;
        cfg_in = din;
        cfg_load = ld;
        @(posedge clk);
        #1;
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        cfg_load = 1'b0;
    endtask

    // MSB first, so r[8W-1] ends at the top of the chain.
    task automatic shift_cfg(input logic [8*W-1:0] r, input bit badpar);
        for (int i = 8*W - 1; i >= 0; i--) cyc(1'b1, r[i], 1'b0);
        if (P != 0) cyc(1'b1, (^r) ^ badpar, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [7:0] pat;
        pat = 8'hA5;

        repeat (2) @(posedge clk);
        #1;
        n_in = 4'hF; e_in = 4'hF; s_in = 4'hF; w_in = 4'hF;
        #1;
        chk("rst north", 32'(north_out), 32'h0);
        chk("rst west",  32'(west_out),  32'h0);
        chk("rst valid", 32'(cfg_valid), 32'h0);
        chk("rst full",  32'(cfg_full),  32'h0);
        chk("rst cfgout", 32'(cfg_out),  32'h0);
        chk("rst r_north", 32'(r_north), 32'h0);
        release_reset();

        shift_cfg(CFG_A, 1'b0);
        chk("full after load", 32'(cfg_full), 32'h1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("ack", 32'(load_ack), 32'h1);
        chk("valid", 32'(cfg_valid), 32'h1);
        n_in = 4'h0; s_in = 4'h0; e_in = 4'hA; w_in = 4'h5;
        #1;
        chk("route N<-E", 32'(north_out), 32'hA);
        chk("route E<-W", 32'(east_out),  32'h5);
        chk("route S<-E", 32'(south_out), 32'hA);
        chk("route W off", 32'(west_out), 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("ack one cycle", 32'(load_ack), 32'h0);

        for (int i = 0; i < CW - 1; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("short err", 32'(cfg_err), 32'h1);
        chk("short no ack", 32'(load_ack), 32'h0);
        chk("short keep route", 32'(north_out), 32'hA);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("retry ack", 32'(load_ack), 32'h1);
        chk("retry err clr", 32'(cfg_err), 32'h0);
        chk("routes off", 32'(north_out), 32'h0);

        for (int i = 1; i <= 40; i++) begin
            cyc(1'b1, pat[7 - ((i - 1) % 8)], 1'b0);
            if (i >= CW && i - CW < 8)
                chk("pass cfg_out", 32'(cfg_out), 32'(pat[7 - (i - CW)]));
        end
        chk("pass full held", 32'(cfg_full), 32'h1);

        shift_cfg(CFG_A, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("simul ack", 32'(load_ack), 32'h1);
        chk("simul route", 32'(north_out), 32'hA);
        chk("simul not full", 32'(cfg_full), 32'h0);
        for (int i = 0; i < CW - 2; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("count from 1", 32'(cfg_full), 32'h0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("count reaches CW", 32'(cfg_full), 32'h1);

`ifdef SWB_CFG_PARITY_EN
        shift_cfg(CFG_A, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("parity err", 32'(cfg_err), 32'h1);
        chk("parity no ack", 32'(load_ack), 32'h0);
`endif

        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("async north", 32'(north_out), 32'h0);
        chk("async south", 32'(south_out), 32'h0);
        chk("async r_north", 32'(r_north), 32'h0);
        chk("async valid", 32'(cfg_valid), 32'h0);
        chk("async full", 32'(cfg_full), 32'h0);
        chk("async cfgout", 32'(cfg_out), 32'h0);
        release_reset();

        n_in = 4'h0; e_in = 4'h0; s_in = 4'h0; w_in = 4'h0;
        shift_cfg(CFG_A, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        e_in = 4'hA;
        #1;
        chk("lag comb", 32'(north_out), 32'hA);
        chk("lag reg old", 32'(r_north), 32'h0);
        @(posedge clk);
        #1;
        chk("lag reg new", 32'(r_north), 32'hA);
        e_in = 4'h0;
        #1;
        chk("lag reg hold", 32'(r_north), 32'hA);
        cyc(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
